// File: rtl/uart_tx.sv
// 8N1 serial transmitter: one byte per valid/ready handshake, LSB first,
// line idles high, bit period of CLKS_PER_BIT clocks from an internal baud counter.
module uart_tx #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_done
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] baud_cnt, baud_cnt_next;
  logic [2:0]    bit_idx, bit_idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic          tx_next, tx_done_next;
  logic          bit_end;

  assign bit_end  = (baud_cnt == LAST_CNT);
  assign tx_ready = (state == IDLE);

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_next    = state;
    baud_cnt_next = baud_cnt;
    bit_idx_next  = bit_idx;
    shift_next    = shift_reg;

    unique case (state)
      IDLE: begin
        if (tx_valid) begin
          shift_next    = tx_data;
          baud_cnt_next = '0;
          state_next    = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          bit_idx_next  = 3'd0;
          state_next    = DATA;
        end else begin
          baud_cnt_next = baud_cnt + CNT_ONE;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          if (bit_idx == 3'd7) state_next = STOP;
          else                 bit_idx_next = bit_idx + 3'd1;
        end else begin
          baud_cnt_next = baud_cnt + CNT_ONE;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          state_next    = IDLE;
        end else begin
          baud_cnt_next = baud_cnt + CNT_ONE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level and done pulse are decoded from the next state so the
    // registered outputs line up with the state they describe.
    unique case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[bit_idx_next];
      default: tx_next = 1'b1;
    endcase
    tx_done_next = (state_next == STOP) && (baud_cnt_next == LAST_CNT);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      // NOTE: the shift register is reset too, so no stale byte survives an aborted frame.
      shift_reg <= '0;
      tx        <= 1'b1;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_next;
      baud_cnt  <= baud_cnt_next;
      bit_idx   <= bit_idx_next;
      shift_reg <= shift_next;
      tx        <= tx_next;
      tx_done   <= tx_done_next;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a frame-level line model (start, data LSB
// first, stop) is compared cycle by cycle against two instances.
module tb_uart_tx;

  localparam int C  = 4;
  localparam int FL = 10 * C;
  // Second instance: bit period not a power of two, so the counter wrap matters.
  localparam int C7 = 7;

  logic       clock = 1'b0;
  logic       resetn;
  logic [7:0] tx_data, tx_data7;
  logic       tx_valid, tx_valid7;
  logic       tx_ready, tx, tx_done;
  logic       tx_ready7, tx7, tx_done7;

  int errors = 0;
  int checks = 0;

  logic obs_tx   [0:127];
  logic obs_rdy  [0:127];
  logic obs_done [0:127];

  always #5 clock = ~clock;

  uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clock(clock), .resetn(resetn), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .tx_done(tx_done)
  );

  uart_tx #(.CLKS_PER_BIT(C7)) dut7 (
    .clock(clock), .resetn(resetn), .tx_data(tx_data7), .tx_valid(tx_valid7),
    .tx_ready(tx_ready7), .tx(tx7), .tx_done(tx_done7)
  );

  // Expected line level j cycles after the accept edge (j=0 is first start-bit cycle).
  function automatic logic line_model(input logic [7:0] b, input int j);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    if (j >= FL) return 1'b1;
    return frame[j / C];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic record(input int start, input int n);
    for (int i = start; i < start + n; i++) begin
      obs_tx[i]   = tx;
      obs_rdy[i]  = tx_ready;
      obs_done[i] = tx_done;
      tick();
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; tx_valid7 = 1'b0; tx_data7 = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({tx, tx_ready, tx_done} !== 3'b110) begin
        errors++; $display("FAIL reset cyc=%0d got tx/rdy/done=%b want 110", i, {tx, tx_ready, tx_done});
      end
      checks++;
      if ({tx7, tx_ready7, tx_done7} !== 3'b110) begin
        errors++; $display("FAIL reset7 cyc=%0d got tx/rdy/done=%b want 110", i, {tx7, tx_ready7, tx_done7});
      end
    end
    // Reset wins over a simultaneous valid.
    tx_valid = 1'b1; tx_data = 8'hFF;
    tick();
    tx_valid = 1'b0;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({tx, tx_ready, tx_done} !== 3'b110) begin
        errors++; $display("FAIL reset_release cyc=%0d got tx/rdy/done=%b want 110", i, {tx, tx_ready, tx_done});
      end
      tick();
    end
  endtask

  task automatic test_single_frame();
    logic [7:0] dec;
    tx_data = 8'hA5; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0; tx_data = 8'($urandom);
    record(0, FL + 1);
    for (int j = 0; j <= FL; j++) begin
      checks++;
      if (obs_tx[j] !== line_model(8'hA5, j) || obs_rdy[j] !== (j == FL) || obs_done[j] !== (j == FL - 1)) begin
        errors++;
        $display("FAIL single j=%0d got tx/rdy/done=%b%b%b want %b%b%b", j, obs_tx[j], obs_rdy[j], obs_done[j],
                 line_model(8'hA5, j), (j == FL), (j == FL - 1));
      end
    end
    for (int k = 0; k < 8; k++) dec[k] = obs_tx[(k + 1) * C + C / 2];
    checks++;
    if (dec !== 8'hA5) begin
      errors++; $display("FAIL single_decode got=%h want=a5", dec);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [2];
    logic [7:0] dec;
    bytes[0] = 8'h00; bytes[1] = 8'hFF;
    tx_data = bytes[0]; tx_valid = 1'b1;
    tick();
    tx_data = bytes[1];
    for (int f = 0; f < 2; f++) begin
      // With valid held, the final recorded cycle (idle) is also the next accept edge.
      if (f == 1) begin
        tx_valid = 1'b0;
      end
      record(0, FL + 1);
      for (int j = 0; j <= FL; j++) begin
        checks++;
        if (obs_tx[j] !== line_model(bytes[f], j) || obs_rdy[j] !== (j == FL) || obs_done[j] !== (j == FL - 1)) begin
          errors++;
          $display("FAIL b2b f=%0d j=%0d got tx/rdy/done=%b%b%b want %b%b%b", f, j, obs_tx[j], obs_rdy[j],
                   obs_done[j], line_model(bytes[f], j), (j == FL), (j == FL - 1));
        end
      end
      for (int k = 0; k < 8; k++) dec[k] = obs_tx[(k + 1) * C + C / 2];
      checks++;
      if (dec !== bytes[f]) begin
        errors++; $display("FAIL b2b_decode f=%0d got=%h want=%h", f, dec, bytes[f]);
      end
    end
  endtask

  task automatic test_ignored_input();
    tx_data = 8'h3C; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    record(0, 5 * C);
    tx_data = 8'hC3; tx_valid = 1'b1;
    record(5 * C, 1);
    tx_valid = 1'b0;
    record(5 * C + 1, FL - 5 * C);
    for (int j = 0; j <= FL; j++) begin
      checks++;
      if (obs_tx[j] !== line_model(8'h3C, j) || obs_rdy[j] !== (j == FL)) begin
        errors++;
        $display("FAIL ignored j=%0d got tx/rdy=%b%b want %b%b", j, obs_tx[j], obs_rdy[j],
                 line_model(8'h3C, j), (j == FL));
      end
    end
    record(0, 12);
    for (int j = 0; j < 12; j++) begin
      checks++;
      if ({obs_tx[j], obs_rdy[j], obs_done[j]} !== 3'b110) begin
        errors++; $display("FAIL ignored_idle j=%0d got tx/rdy/done=%b%b%b want 110", j, obs_tx[j], obs_rdy[j], obs_done[j]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    tx_data = 8'h55; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    // Data bit 3 spans j = 4C .. 5C-1; abort partway through it.
    record(0, 4 * C + 1);
    for (int j = 0; j <= 4 * C; j++) begin
      checks++;
      if (obs_tx[j] !== line_model(8'h55, j) || obs_done[j] !== 1'b0) begin
        errors++; $display("FAIL abort_pre j=%0d got tx/done=%b%b want %b0", j, obs_tx[j], obs_done[j], line_model(8'h55, j));
      end
    end
    resetn = 1'b0;
    tick();
    checks++;
    if ({tx, tx_ready, tx_done} !== 3'b110) begin
      errors++; $display("FAIL abort_next got tx/rdy/done=%b want 110", {tx, tx_ready, tx_done});
    end
    resetn = 1'b1;
    record(0, FL);
    for (int j = 0; j < FL; j++) begin
      checks++;
      if ({obs_tx[j], obs_rdy[j], obs_done[j]} !== 3'b110) begin
        errors++; $display("FAIL abort_idle j=%0d got tx/rdy/done=%b%b%b want 110", j, obs_tx[j], obs_rdy[j], obs_done[j]);
      end
    end
    tx_data = 8'h81; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    record(0, FL + 1);
    for (int j = 0; j <= FL; j++) begin
      checks++;
      if (obs_tx[j] !== line_model(8'h81, j) || obs_rdy[j] !== (j == FL) || obs_done[j] !== (j == FL - 1)) begin
        errors++;
        $display("FAIL after_abort j=%0d got tx/rdy/done=%b%b%b want %b%b%b", j, obs_tx[j], obs_rdy[j],
                 obs_done[j], line_model(8'h81, j), (j == FL), (j == FL - 1));
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int gap;
    for (int f = 0; f < 8; f++) begin
      b   = 8'($urandom);
      gap = int'($urandom_range(0, 3));
      repeat (gap) tick();
      tx_data = b; tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0; tx_data = 8'($urandom);
      record(0, FL + 1);
      for (int j = 0; j <= FL; j++) begin
        checks++;
        if (obs_tx[j] !== line_model(b, j) || obs_rdy[j] !== (j == FL) || obs_done[j] !== (j == FL - 1)) begin
          errors++;
          $display("FAIL random f=%0d b=%h j=%0d got tx/rdy/done=%b%b%b want %b%b%b", f, b, j, obs_tx[j],
                   obs_rdy[j], obs_done[j], line_model(b, j), (j == FL), (j == FL - 1));
        end
      end
    end
  endtask

  task automatic test_baud();
    int run_start, run_b0, run_low, run_stop, done_cnt, done_pos;
    tx_data7 = 8'h01; tx_valid7 = 1'b1;
    tick();
    tx_valid7 = 1'b0;
    run_start = 0; while (tx7 === 1'b0 && run_start < 1000) begin run_start++; tick(); end
    run_b0    = 0; while (tx7 === 1'b1 && run_b0 < 1000)    begin run_b0++;    tick(); end
    run_low   = 0; while (tx7 === 1'b0 && run_low < 1000)   begin run_low++;   tick(); end
    run_stop = 0; done_cnt = 0; done_pos = -1;
    while (tx_ready7 !== 1'b1 && run_stop < 1000) begin
      if (tx_done7 === 1'b1) begin done_cnt++; done_pos = run_stop; end
      run_stop++;
      tick();
    end
    checks++;
    if (run_start != C7) begin errors++; $display("FAIL baud_start got=%0d want=%0d", run_start, C7); end
    checks++;
    if (run_b0 != C7) begin errors++; $display("FAIL baud_bit0 got=%0d want=%0d", run_b0, C7); end
    checks++;
    if (run_low != 7 * C7) begin errors++; $display("FAIL baud_bits1_7 got=%0d want=%0d", run_low, 7 * C7); end
    checks++;
    if (run_stop != C7) begin errors++; $display("FAIL baud_stop got=%0d want=%0d", run_stop, C7); end
    checks++;
    if (done_cnt != 1 || done_pos != C7 - 1) begin
      errors++; $display("FAIL baud_done got cnt=%0d pos=%0d want cnt=1 pos=%0d", done_cnt, done_pos, C7 - 1);
    end
    checks++;
    if (run_start + run_b0 + run_low + run_stop != 10 * C7) begin
      errors++; $display("FAIL baud_frame got=%0d want=%0d", run_start + run_b0 + run_low + run_stop, 10 * C7);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_ignored_input();
    test_reset_mid_frame();
    test_random();
    test_baud();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
